regfile_wb_buffer: RTL

- Writeback staging buffer that drives the regfile write ports.
- Accepts one result per cycle (rd address plus data) from the functional-unit side and queues it in FIFO order.
- Drains up to NR_WB_PORTS entries per cycle into the regfile's waddr/wdata/we ports.
- Forwards data from pending (not yet written) entries to read ports so operand reads see the newest value.

---
 rtl/regfile_wb_buffer_if.sv | 12 +
 rtl/regfile_wb_buffer.sv | 106 ++++++++++
 2 files changed

// File: rtl/regfile_wb_buffer_if.sv
// Producer-side result handshake for the writeback staging buffer.
interface regfile_wb_buffer_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4:0]            in_waddr;
    logic [DATA_WIDTH-1:0] in_wdata;

    modport master (output in_valid, in_waddr, in_wdata, input in_ready);
    modport slave  (input in_valid, in_waddr, in_wdata, output in_ready);
endinterface

// File: rtl/regfile_wb_buffer.sv
// Writeback staging FIFO: queues results, drains up to NR_WB_PORTS per cycle
// into the regfile and forwards pending values to operand read ports.
module regfile_wb_buffer #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned NR_WB_PORTS   = 2,
    parameter int unsigned NR_READ_PORTS = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    regfile_wb_buffer_if.slave                       in_if,
    input  logic                                     drain_en_i,
    output logic [NR_WB_PORTS-1:0][4:0]              waddr_o,
    output logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0]   wdata_o,
    output logic [NR_WB_PORTS-1:0]                   we_o,
    input  logic [NR_READ_PORTS-1:0][4:0]            raddr_i,
    output logic [NR_READ_PORTS-1:0]                 fwd_hit_o,
    output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] fwd_data_o,
    output logic [$clog2(DEPTH):0]                   count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [4:0]            addr_q [DEPTH];
    logic [4:0]            addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d, n_drain;
    logic                  push, enq;

    assign in_if.in_ready = (count_q != CW'(DEPTH));
    assign count_o        = count_q;

    always_comb begin
        n_drain = '0;
        if (drain_en_i)
            n_drain = (count_q < CW'(NR_WB_PORTS)) ? count_q : CW'(NR_WB_PORTS);
        for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
            we_o[k]    = 1'b0;
            waddr_o[k] = '0;
            wdata_o[k] = '0;
            if (CW'(k) < n_drain) begin
                we_o[k]    = 1'b1;
                waddr_o[k] = addr_q[head_q + PW'(k)];
                wdata_o[k] = data_q[head_q + PW'(k)];
            end
        end
    end

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        for (int unsigned r = 0; r < NR_READ_PORTS; r++) begin
            fwd_hit_o[r]  = 1'b0;
            fwd_data_o[r] = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count_q) && (raddr_i[r] != 5'd0) &&
                    (addr_q[head_q + PW'(i)] == raddr_i[r])) begin
                    fwd_hit_o[r]  = 1'b1;
                    fwd_data_o[r] = data_q[head_q + PW'(i)];
                end
            end
        end
    end

    always_comb begin
        push   = in_if.in_valid && in_if.in_ready;
        enq    = push && (in_if.in_waddr != 5'd0);
        addr_d = addr_q;
        data_d = data_q;
        tail_d = tail_q;
        if (enq) begin
            addr_d[tail_q] = in_if.in_waddr;
            data_d[tail_q] = in_if.in_wdata;
            tail_d         = tail_q + 1'b1;
        end
        head_d  = head_q + n_drain[PW-1:0];
        count_d = count_q + CW'(enq) - n_drain;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= CW'(DEPTH));
    a_push_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (in_if.in_valid && !in_if.in_ready) |=>
        (in_if.in_valid && $stable(in_if.in_waddr) && $stable(in_if.in_wdata)));
`endif
endmodule
